// File: rtl/eq_gain_sequencer.sv
// Per-band equalizer gain sequencer: holds target/applied gains per band and
// ramps applied gains one LSB per sample tick toward their targets.
module eq_gain_sequencer #(
   parameter int unsigned NUMBER_OF_FILTERS = 8,
   parameter int unsigned GAIN_BITS         = 2,
   parameter int unsigned RESET_GAIN        = 1,
   parameter int unsigned BAND_BITS         = $clog2(NUMBER_OF_FILTERS)
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   clk_enable,
   input  logic                                   phase_min,
   input  logic                                   wr_valid,
   output logic                                   wr_ready,
   input  logic [BAND_BITS-1:0]                   wr_band,
   input  logic [GAIN_BITS-1:0]                   wr_gain,
   input  logic                                   en_req,
   output logic                                   amplifier_enable,
   output logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] amplifier_gains,
   output logic                                   ramping,
   output logic                                   commit,
   output logic                                   wr_err
);

   typedef enum logic {
      IDLE = 1'b0,
      RAMP = 1'b1
   } state_t;

   typedef logic [NUMBER_OF_FILTERS-1:0][GAIN_BITS-1:0] gain_arr_t;

   localparam gain_arr_t RESET_ARR = {NUMBER_OF_FILTERS{GAIN_BITS'(RESET_GAIN)}};

   state_t     state, state_nxt;
   gain_arr_t  target, target_nxt;
   gain_arr_t  applied, applied_nxt;
   logic       enable_q, enable_nxt;
   logic       commit_q, commit_nxt;
   logic       wr_err_q, wr_err_nxt;
   logic       tick;
   logic       wr_fire;
   logic [31:0] band_ext;

   // Writes are refused on the step edge so a step never sees a half-written target.
   assign tick     = clk_enable & phase_min;
   assign wr_ready = ~tick;
   assign wr_fire  = wr_valid & ~tick;
   assign band_ext = 32'(wr_band);

   assign amplifier_gains  = applied;
   assign amplifier_enable = enable_q;
   assign ramping          = (state == RAMP);
   assign commit           = commit_q;
   assign wr_err           = wr_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         target   <= RESET_ARR;
         applied  <= RESET_ARR;
         enable_q <= 1'b0;
         commit_q <= 1'b0;
         wr_err_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         target   <= target_nxt;
         applied  <= applied_nxt;
         enable_q <= enable_nxt;
         commit_q <= commit_nxt;
         wr_err_q <= wr_err_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      target_nxt  = target;
      applied_nxt = applied;
      enable_nxt  = enable_q;
      commit_nxt  = 1'b0;
      wr_err_nxt  = 1'b0;

      if (wr_fire) begin
         if (band_ext >= NUMBER_OF_FILTERS) begin
            wr_err_nxt = 1'b1;
         end else begin
            for (int unsigned i = 0; i < NUMBER_OF_FILTERS; i++) begin
               if (band_ext == 32'(i)) target_nxt[i] = wr_gain;
            end
         end
      end

      // All bands step in parallel, saturating naturally at the target.
      if (tick && (state == RAMP)) begin
         for (int unsigned i = 0; i < NUMBER_OF_FILTERS; i++) begin
            if (applied[i] < target[i]) begin
               applied_nxt[i] = applied[i] + GAIN_BITS'(1);
               commit_nxt     = 1'b1;
            end else if (applied[i] > target[i]) begin
               applied_nxt[i] = applied[i] - GAIN_BITS'(1);
               commit_nxt     = 1'b1;
            end
         end
      end

      if (tick) enable_nxt = en_req;

      state_nxt = (applied_nxt != target_nxt) ? RAMP : IDLE;
   end

endmodule

// File: tb/tb_eq_gain_sequencer.sv
// Scoreboard bench for eq_gain_sequencer: stimulus queues expected gains per
// commit / wr_err pulse, a negedge monitor pops and compares them.
module tb_eq_gain_sequencer;

   localparam int unsigned NF = 8;
   localparam int unsigned GB = 2;
   localparam int unsigned BB = 4;

   typedef struct {
      logic [NF*GB-1:0] gains;
      logic             ramping;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             clk_enable;
   logic             phase_min;
   logic             wr_valid;
   logic             wr_ready;
   logic [BB-1:0]    wr_band;
   logic [GB-1:0]    wr_gain;
   logic             en_req;
   logic             amplifier_enable;
   logic [NF*GB-1:0] amplifier_gains;
   logic             ramping;
   logic             commit;
   logic             wr_err;

   int   checks = 0;
   int   errors = 0;
   exp_t commit_q[$];
   exp_t err_q[$];

   eq_gain_sequencer #(
      .NUMBER_OF_FILTERS(NF),
      .GAIN_BITS        (GB),
      .RESET_GAIN       (1),
      .BAND_BITS        (BB)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .clk_enable      (clk_enable),
      .phase_min       (phase_min),
      .wr_valid        (wr_valid),
      .wr_ready        (wr_ready),
      .wr_band         (wr_band),
      .wr_gain         (wr_gain),
      .en_req          (en_req),
      .amplifier_enable(amplifier_enable),
      .amplifier_gains (amplifier_gains),
      .ramping         (ramping),
      .commit          (commit),
      .wr_err          (wr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_commit(input logic [NF*GB-1:0] g, input logic r);
      exp_t e;
      e.gains   = g;
      e.ramping = r;
      commit_q.push_back(e);
   endtask

   task automatic push_err(input logic [NF*GB-1:0] g, input logic r);
      exp_t e;
      e.gains   = g;
      e.ramping = r;
      err_q.push_back(e);
   endtask

   task automatic do_write(input logic [BB-1:0] b, input logic [GB-1:0] g);
      @(posedge clk); #1;
      wr_valid = 1'b1;
      wr_band  = b;
      wr_gain  = g;
      @(posedge clk); #1;
      wr_valid = 1'b0;
   endtask

   task automatic do_tick();
      @(posedge clk); #1;
      phase_min = 1'b1;
      @(posedge clk); #1;
      phase_min = 1'b0;
   endtask

   // Monitor: every commit / wr_err pulse must match the next queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (commit === 1'b1) begin
         if (commit_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_commit: got gains 0x%0h with no expected step", amplifier_gains);
         end else begin
            e = commit_q.pop_front();
            chk("commit_gains", 32'(amplifier_gains), 32'(e.gains));
            chk("commit_ramping", 32'(ramping), 32'(e.ramping));
         end
      end
      if (wr_err === 1'b1) begin
         if (err_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wr_err: got wr_err 1 expected 0");
         end else begin
            e = err_q.pop_front();
            chk("wr_err_gains", 32'(amplifier_gains), 32'(e.gains));
            chk("wr_err_ramping", 32'(ramping), 32'(e.ramping));
         end
      end
   end

   initial begin
      rst_n      = 1'b0;
      clk_enable = 1'b1;
      phase_min  = 1'b0;
      wr_valid   = 1'b0;
      wr_band    = '0;
      wr_gain    = '0;
      en_req     = 1'b0;

      // Reset values
      #12;
      chk("rst_gains", 32'(amplifier_gains), 32'h5555);
      chk("rst_enable", 32'(amplifier_enable), 32'h0);
      chk("rst_ramping", 32'(ramping), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("post_rst_gains", 32'(amplifier_gains), 32'h5555);
      chk("post_rst_wr_ready", 32'(wr_ready), 32'h1);

      // Band 3 -> 3 with ticks every 64 clocks; enable only moves on a tick
      en_req = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("enable_waits_tick", 32'(amplifier_enable), 32'h0);
      do_write(4'd3, 2'd3);
      chk("ramp_start", 32'(ramping), 32'h1);
      repeat (62) @(posedge clk);
      push_commit(16'h5595, 1'b1);
      do_tick();
      chk("enable_on_tick", 32'(amplifier_enable), 32'h1);
      repeat (62) @(posedge clk);
      push_commit(16'h55D5, 1'b0);
      do_tick();
      chk("ramp_done", 32'(ramping), 32'h0);

      // Write held across a tick: refused on the tick edge, taken the next
      @(posedge clk); #1;
      phase_min = 1'b1;
      wr_valid  = 1'b1;
      wr_band   = 4'd3;
      wr_gain   = 2'd0;
      #1 chk("wr_ready_on_tick", 32'(wr_ready), 32'h0);
      @(posedge clk); #1;
      phase_min = 1'b0;
      chk("held_write_gains", 32'(amplifier_gains), 32'h55D5);
      chk("held_write_idle", 32'(ramping), 32'h0);
      #1 chk("wr_ready_off_tick", 32'(wr_ready), 32'h1);
      @(posedge clk); #1;
      wr_valid = 1'b0;
      chk("held_write_taken", 32'(ramping), 32'h1);
      push_commit(16'h5595, 1'b1);
      do_tick();
      push_commit(16'h5555, 1'b1);
      do_tick();
      push_commit(16'h5515, 1'b0);
      do_tick();

      // Out-of-range band
      push_err(16'h5515, 1'b0);
      do_write(4'd9, 2'd2);
      @(posedge clk); #1;
      chk("bad_band_idle", 32'(ramping), 32'h0);
      do_tick();
      chk("bad_band_gains", 32'(amplifier_gains), 32'h5515);

      // Band 0 down, band 7 up then retargeted mid-ramp; gated ticks ignored
      do_write(4'd0, 2'd0);
      do_write(4'd7, 2'd3);
      push_commit(16'h9514, 1'b1);
      do_tick();
      do_write(4'd7, 2'd1);
      en_req = 1'b0;
      @(posedge clk); #1;
      clk_enable = 1'b0;
      phase_min  = 1'b1;
      #1 chk("wr_ready_gated", 32'(wr_ready), 32'h1);
      repeat (3) @(posedge clk);
      #1;
      chk("gated_gains", 32'(amplifier_gains), 32'h9514);
      chk("gated_enable", 32'(amplifier_enable), 32'h1);
      clk_enable = 1'b1;
      phase_min  = 1'b0;
      push_commit(16'h5514, 1'b0);
      do_tick();
      chk("retarget_done", 32'(ramping), 32'h0);
      chk("enable_off_tick", 32'(amplifier_enable), 32'h0);

      // Asynchronous reset in the middle of a ramp
      en_req = 1'b1;
      do_write(4'd5, 2'd3);
      push_commit(16'h5914, 1'b1);
      do_tick();
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_gains", 32'(amplifier_gains), 32'h5555);
      chk("async_rst_ramping", 32'(ramping), 32'h0);
      chk("async_rst_commit", 32'(commit), 32'h0);
      chk("async_rst_enable", 32'(amplifier_enable), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_tick();
      chk("post_rst_tick_gains", 32'(amplifier_gains), 32'h5555);
      chk("post_rst_tick_ramping", 32'(ramping), 32'h0);
      chk("post_rst_tick_enable", 32'(amplifier_enable), 32'h1);

      repeat (3) @(posedge clk);
      #1;
      chk("pending_commits", 32'(commit_q.size()), 32'h0);
      chk("pending_wr_errs", 32'(err_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/eq_gain_sequencer.md
EQ_GAIN_SEQUENCER -- requirements
Module: eq_gain_sequencer

Interface
REQ-001 SHALL have parameter NUMBER_OF_FILTERS, default 8, number of equalizer bands.
REQ-002 SHALL have parameter GAIN_BITS, default 2, unsigned gain width per band.
REQ-003 SHALL have parameter RESET_GAIN, default 1, gain loaded into every band at reset.
REQ-004 SHALL have parameter BAND_BITS, default $clog2(NUMBER_OF_FILTERS), band index width.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port clk_enable  input  1  global datapath enable; no state advances when low.
REQ-009 SHALL have port phase_min  input  1  sample-boundary strobe from the tap counter.
REQ-010 SHALL have port wr_valid  input  1  gain write request.
REQ-011 SHALL have port wr_ready  output  1  gain write accepted this cycle when high with wr_valid.
REQ-012 SHALL have port wr_band  input  BAND_BITS  target band index.
REQ-013 SHALL have port wr_gain  input  GAIN_BITS  requested target gain.
REQ-014 SHALL have port en_req  input  1  requested amplifier enable.
REQ-015 SHALL have port amplifier_enable  output  1  registered enable to the amplifier.
REQ-016 SHALL have port amplifier_gains  output  NUMBER_OF_FILTERS*GAIN_BITS  applied gains, band i at bits [(i+1)*GAIN_BITS-1 : i*GAIN_BITS].
REQ-017 SHALL have port ramping  output  1  high while state is RAMP.
REQ-018 SHALL have port commit  output  1  one-cycle pulse when any applied gain changed.
REQ-019 SHALL have port wr_err  output  1  one-cycle pulse on accepted write with wr_band >= NUMBER_OF_FILTERS.

Function
REQ-020 SHALL define tick = clk_enable && phase_min; all applied-gain and enable changes occur only on the clock edge where tick is high.
REQ-021 SHALL hold a target register and an applied register per band; amplifier_gains SHALL be the applied registers directly.
REQ-022 SHALL drive wr_ready = !tick (combinational), so writes never coincide with a step.
REQ-023 SHALL, on wr_valid && wr_ready with wr_band < NUMBER_OF_FILTERS, load target[wr_band] = wr_gain on that edge; a later write to the same band overwrites the target.
REQ-024 SHALL, on an accepted write with wr_band >= NUMBER_OF_FILTERS, leave all targets unchanged and pulse wr_err the next cycle.
REQ-025 SHALL implement states IDLE (all applied == target) and RAMP (any differ).
REQ-026 SHALL transition IDLE->RAMP on the edge after an accepted write whose wr_gain differs from applied[wr_band]; a write equal to applied stays IDLE.
REQ-027 SHALL, on each tick in RAMP, move every band with applied != target by exactly one LSB toward target (unsigned, no wrap), bands in parallel.
REQ-028 SHALL transition RAMP->IDLE on the tick after which all applied equal target; latency from write to final gain is |target-applied| ticks.
REQ-029 SHALL pulse commit for one cycle, registered, on the edge after a tick that changed at least one applied gain.
REQ-030 SHALL update amplifier_enable to en_req on each tick, independent of state; en_req changes between ticks are ignored until the next tick.
REQ-031 SHALL ignore phase_min when clk_enable is low (no step, no enable update, wr_ready high).

Reset
REQ-032 SHALL, while rst_n is low, force all targets and applied gains to RESET_GAIN, amplifier_enable=0, state=IDLE, ramping=0, commit=0, wr_err=0, asynchronously.
REQ-033 SHALL, on reset mid-ramp, abandon the ramp; first post-reset tick changes nothing unless a write was accepted.

Verification
REQ-034 SHALL verify: reset release -> amplifier_gains = 0x5555 (8 bands x gain 1), amplifier_enable=0, ramping=0.
REQ-035 SHALL verify: write band 3 gain 3, ticks every 64 clocks -> band 3 steps 1->2->3 on two consecutive ticks, commit pulses twice, ramping falls after second tick.
REQ-036 SHALL verify: wr_valid held high on a tick cycle -> wr_ready=0 that cycle, write taken next cycle, no step uses the new target on that tick.
REQ-037 SHALL verify: write band 9 -> wr_err pulses once, gains unchanged, state stays IDLE.
REQ-038 SHALL verify: band 0 target 0 and band 7 target 3 written, then band 7 rewritten to 1 mid-ramp -> band 0 reaches 0 after 1 tick, band 7 returns to 1; clk_enable low with phase_min high -> no change.
REQ-039 SHALL verify: rst_n asserted mid-ramp -> outputs return to REQ-032 values immediately, without a clock edge.
